tl_ul_reg_master: RTL and testbench
===================================

Name: tl_ul_reg_master

Overview:
- Single-outstanding TileLink-UL master that turns a simple register request/response port into A-channel Get/PutFullData beats and D-channel responses.
- Sits directly upstream of the TileLink async crossing source. Its A outputs drive the crossing's inbound A channel (opcode, 9-bit address, 32-bit data); its D inputs consume the crossing's D channel.
- Adds local misalignment rejection, response checking and a response timeout, so a dead far clock domain cannot hang the register port.

Parameters:
- ADDR_W, 9, A-channel address width.
- DATA_W, 32, data width; always a full-word (4-byte) access.
- TIMEOUT_CYCLES, 1024, D_WAIT cycles before a timeout response; 0 disables the timeout.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  register request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_write  in  1  1=write (PutFullData), 0=read (Get).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_error  out  1  denied/corrupt/mismatch/misaligned/timeout.
- rsp_timeout  out  1  response produced by timeout.
- a_valid  out  1;  a_ready  in  1;  a_opcode  out  3;  a_address  out  ADDR_W;  a_data  out  DATA_W.
- d_valid  in  1;  d_ready  out  1;  d_opcode  in  3;  d_param  in  2;  d_size  in  2;  d_source  in  1;  d_sink  in  1;  d_denied  in  1;  d_data  in  DATA_W;  d_corrupt  in  1.
- busy  out  1  state != IDLE.
- proto_err  out  1  sticky: unexpected D beat; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, stale=0, proto_err=0, counter=0, captured registers=0.
  - While reset is high, req_ready, a_valid, d_ready and rsp_valid are forced to 0.
- FSM states: IDLE, A_SEND, D_WAIT, RSP. All outputs are driven from registers or state; there is no combinational path from req to A or from D to rsp.
- IDLE:
  - req_ready=1.
  - On req_valid, capture write/addr/wdata.
  - If addr[1:0]!=0: go to RSP with error=1, rdata=0, no A beat.
  - Otherwise go to A_SEND.
- A_SEND:
  - a_valid=1. a_opcode=0 (PutFullData) for writes, 4 (Get) for reads. a_address and a_data come from the captured registers. a_data=0 for reads.
  - A payload is held stable until a_ready.
  - On a_valid&a_ready: go to D_WAIT, counter=0.
- D_WAIT:
  - d_ready=1; the counter increments each cycle without a D handshake.
  - On D handshake with stale=1: stale response; clear stale, reset counter, stay in D_WAIT.
  - On D handshake with stale=0:
    - error = d_denied | (read & d_corrupt) | opcode mismatch | d_source!=0.
    - Expected opcode: 0 (AccessAck) for write, 1 (AccessAckData) for read.
    - rdata = d_data if read and no error, else 0.
    - Go to RSP.
  - Timeout: if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no D handshake this cycle:
    - Go to RSP with error=1, timeout=1, rdata=0; set stale=1.
    - A D handshake in that same cycle wins over the timeout.
- RSP:
  - rsp_valid=1 and rsp_* held stable until rsp_ready; then go to IDLE.
  - req_ready=0 in RSP; there is no bypass.
- D handshakes outside D_WAIT:
  - d_ready=1 in IDLE, A_SEND and RSP; any beat there is discarded.
  - If stale=1: clear stale, no error.
  - If stale=0: set proto_err.
- Latency:
  - Request accept to a_valid: 1 cycle.
  - D handshake to rsp_valid: 1 cycle.
  - Minimum round trip: req accept -> rsp_valid = 3 cycles with a_ready and d_valid already high.
- Counter width: clog2(TIMEOUT_CYCLES+1); saturates and never wraps.
- Reset mid-transaction: drops all state, including stale, so a late D beat sets proto_err.

Decomposition:
- Shared package tl_ul_pkg holds:
  - A opcodes: PUT_FULL=0, GET=4.
  - D opcodes: ACCESS_ACK=0, ACCESS_ACK_DATA=1.
  - FSM state enum; SIZE_WORD=2.
- One sub-module, tl_ul_timeout: a saturating counter with clear/enable inputs and an expire output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Read, a_ready=1, D opcode=1, data=0xDEADBEEF one cycle after the A beat -> a_opcode=4, a_address=0x004; rsp_valid 3 cycles after accept; rdata=0xDEADBEEF, error=0.
- Write addr 0x010, wdata 0x12345678; hold a_ready=0 for 5 cycles -> A payload stable all 5 cycles; D opcode=0 -> rsp error=0, rdata=0.
- Read addr 0x003 -> no a_valid; rsp error=1 on the cycle after accept. Read with d_denied=1 -> error=1, rdata=0.
- TIMEOUT_CYCLES=8, no D -> rsp error=1, timeout=1 after 8 D_WAIT cycles. A late D beat in IDLE clears stale with proto_err=0. A second late beat sets proto_err=1.
- Read answered with D opcode=0 (mismatch) -> error=1. Unsolicited D in IDLE -> proto_err=1. Reset asserted in D_WAIT -> next cycle busy=0, req_ready=1.
- rsp_ready held low 10 cycles while req_valid=1 -> req_ready=0 and rsp_* stable throughout; the next request is accepted the cycle after rsp_ready.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// rtl/tl_ul_pkg.sv - shared TileLink-UL opcodes, sizes and register-master FSM states
package tl_ul_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] GET             = 3'd4;

    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    localparam logic [1:0] SIZE_WORD       = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_A_SEND = 2'd1,
        ST_D_WAIT = 2'd2,
        ST_RSP    = 2'd3
    } master_state_e;

endpackage

// File: rtl/tl_ul_timeout.sv
// rtl/tl_ul_timeout.sv - saturating response-wait counter with clear/enable and expire
module tl_ul_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,   // restart the wait window from zero
    input  logic enable,  // count this cycle
    output logic expire   // counter sits on the last cycle of the window
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at TIMEOUT_CYCLES so a stuck enable can never wrap back into the window.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CNT_SAT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A zero window disables the timeout entirely.
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/tl_ul_reg_master.sv
// rtl/tl_ul_reg_master.sv - single-outstanding TileLink-UL master behind a register req/rsp port
module tl_ul_reg_master
    import tl_ul_pkg::*;
#(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              rsp_timeout,

    output logic              a_valid,
    input  logic              a_ready,
    output logic [2:0]        a_opcode,
    output logic [ADDR_W-1:0] a_address,
    output logic [DATA_W-1:0] a_data,

    input  logic              d_valid,
    output logic              d_ready,
    input  logic [2:0]        d_opcode,
    input  logic [1:0]        d_param,
    input  logic [1:0]        d_size,
    input  logic              d_source,
    input  logic              d_sink,
    input  logic              d_denied,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_corrupt,

    output logic              busy,
    output logic              proto_err   // sticky until reset
);

    master_state_e     state_q, state_d;
    logic              cap_write_q, cap_write_d;
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              error_q, error_d;
    logic              timeout_q, timeout_d;
    logic              stale_q, stale_d;     // a timed-out response may still arrive
    logic              proto_err_q, proto_err_d;

    logic              d_hs;
    logic              d_err;
    logic [2:0]        exp_d_opcode;
    logic              tmo_clear;
    logic              tmo_enable;
    logic              tmo_expire;

    // Fields the far side returns but this master has no use for.
    logic              unused_d_fields;
    assign unused_d_fields = ^{d_param, d_size, d_sink};

    assign d_hs = d_valid && d_ready;

    assign exp_d_opcode = cap_write_q ? ACCESS_ACK : ACCESS_ACK_DATA;
    assign d_err = d_denied
                 | (~cap_write_q & d_corrupt)
                 | (d_opcode != exp_d_opcode)
                 | (d_source != 1'b0);

    // Window restarts on entry to D_WAIT and after a discarded stale beat.
    assign tmo_clear  = (state_q != ST_D_WAIT) || (d_hs && stale_q);
    assign tmo_enable = (state_q == ST_D_WAIT) && !d_hs;

    tl_ul_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expire (tmo_expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cap_write_q <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            timeout_q   <= 1'b0;
            stale_q     <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_write_q <= cap_write_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            timeout_q   <= timeout_d;
            stale_q     <= stale_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cap_write_d = cap_write_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        timeout_d   = timeout_q;
        stale_d     = stale_q;
        proto_err_d = proto_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cap_write_d = req_write;
                    cap_addr_d  = req_addr;
                    // Reads put zero on a_data, so capture zero for them.
                    cap_wdata_d = req_write ? req_wdata : '0;
                    if (req_addr[1:0] != 2'b00) begin
                        state_d   = ST_RSP;
                        rdata_d   = '0;
                        error_d   = 1'b1;
                        timeout_d = 1'b0;
                    end else begin
                        state_d   = ST_A_SEND;
                    end
                end
            end

            ST_A_SEND: begin
                if (a_ready) begin
                    state_d = ST_D_WAIT;
                end
            end

            ST_D_WAIT: begin
                if (d_hs) begin
                    if (stale_q) begin
                        stale_d = 1'b0;
                    end else begin
                        state_d   = ST_RSP;
                        error_d   = d_err;
                        timeout_d = 1'b0;
                        rdata_d   = (!cap_write_q && !d_err) ? d_data : '0;
                    end
                end else if (tmo_expire) begin
                    // Far side may still answer later; remember to swallow it.
                    state_d   = ST_RSP;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                    rdata_d   = '0;
                    stale_d   = 1'b1;
                end
            end

            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Beats outside D_WAIT are always dropped; only a pending stale one is legitimate.
        if (d_hs && (state_q != ST_D_WAIT)) begin
            if (stale_q) begin
                stale_d = 1'b0;
            end else begin
                proto_err_d = 1'b1;
            end
        end
    end

    assign req_ready   = (state_q == ST_IDLE)   && !reset;
    assign a_valid     = (state_q == ST_A_SEND) && !reset;
    assign rsp_valid   = (state_q == ST_RSP)    && !reset;
    assign d_ready     = !reset;

    assign a_opcode    = cap_write_q ? PUT_FULL : GET;
    assign a_address   = cap_addr_q;
    assign a_data      = cap_wdata_q;

    assign rsp_rdata   = rdata_q;
    assign rsp_error   = error_q;
    assign rsp_timeout = timeout_q;

    assign busy        = (state_q != ST_IDLE);
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_tl_ul_reg_master.sv
// tb/tb_tl_ul_reg_master.sv - self-checking bench for tl_ul_reg_master
module tb_tl_ul_reg_master;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [DATA_W-1:0] rsp_rdata;
    logic              a_valid, a_ready;
    logic [2:0]        a_opcode;
    logic [ADDR_W-1:0] a_address;
    logic [DATA_W-1:0] a_data;
    logic              d_valid, d_ready;
    logic [2:0]        d_opcode;
    logic [1:0]        d_param, d_size;
    logic              d_source, d_sink, d_denied, d_corrupt;
    logic [DATA_W-1:0] d_data;
    logic              busy, proto_err;

    always #5 clock = ~clock;

    tl_ul_reg_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
        .a_address(a_address), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
        .d_data(d_data), .d_corrupt(d_corrupt),
        .busy(busy), .proto_err(proto_err)
    );

    typedef struct {
        logic        write;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          stall;
        logic [2:0]  dop;
        logic        denied;
        logic        corrupt;
        logic        source;
        logic [31:0] ddata;
        logic        exp_no_a;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t sb_q[$];
    vec_t vecs[11];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic w, logic [8:0] a, logic [31:0] wd, int st,
                                logic [2:0] dop, logic den, logic cor, logic src,
                                logic [31:0] dd, logic no_a, logic err, logic [31:0] rd);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.stall = st;
        v.dop = dop; v.denied = den; v.corrupt = cor; v.source = src; v.ddata = dd;
        v.exp_no_a = no_a; v.exp_err = err; v.exp_rdata = rd;
        return v;
    endfunction

    function automatic rsp_t mk_rsp(logic [31:0] rd, logic err, logic tmo);
        rsp_t r;
        r.rdata = rd; r.err = err; r.tmo = tmo;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic d_beat(input logic [2:0] op, input logic den, input logic cor,
                          input logic src, input logic [31:0] data);
        d_valid = 1'b1; d_opcode = op; d_denied = den; d_corrupt = cor;
        d_source = src; d_data = data; d_size = 2'd2;
        tick();
        d_valid = 1'b0; d_opcode = 3'd0; d_denied = 1'b0; d_corrupt = 1'b0;
        d_source = 1'b0; d_data = '0;
    endtask

    task automatic issue(input logic w, input logic [8:0] a, input logic [31:0] wd);
        int n;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) check("req_accept_wait", 64'd0, 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic collect_rsp(input string name);
        int   n;
        rsp_t e;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        if (!rsp_valid) begin
            check({name, "_rsp_wait"}, 64'd0, 64'd1);
        end else if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({name, "_rdata"},   rsp_rdata,   e.rdata);
            check({name, "_error"},   rsp_error,   e.err);
            check({name, "_timeout"}, rsp_timeout, e.tmo);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string nm;
        nm = $sformatf("vec%0d", idx);
        sb_q.push_back(mk_rsp(v.exp_rdata, v.exp_err, 1'b0));
        issue(v.write, v.addr, v.wdata);
        if (v.exp_no_a) begin
            check({nm, "_no_a_valid"}, a_valid, 1'b0);
            check({nm, "_rsp_latency"}, rsp_valid, 1'b1);
        end else begin
            if (v.stall == 0) a_ready = 1'b1;
            check({nm, "_a_valid"},   a_valid,   1'b1);
            check({nm, "_a_opcode"},  a_opcode,  v.write ? 3'd0 : 3'd4);
            check({nm, "_a_address"}, a_address, v.addr);
            check({nm, "_a_data"},    a_data,    v.write ? v.wdata : 32'd0);
            for (int i = 0; i < v.stall; i++) begin
                tick();
                check({nm, "_stall_a_valid"}, a_valid,   1'b1);
                check({nm, "_stall_addr"},    a_address, v.addr);
                check({nm, "_stall_data"},    a_data,    v.write ? v.wdata : 32'd0);
            end
            a_ready = 1'b1;
            tick();
            a_ready = 1'b0;
            check({nm, "_a_done"}, a_valid, 1'b0);
            d_beat(v.dop, v.denied, v.corrupt, v.source, v.ddata);
            check({nm, "_rsp_latency"}, rsp_valid, 1'b1);
        end
        collect_rsp(nm);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_a_valid",   a_valid,   1'b0);
        check("rst_d_ready",   d_ready,   1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        reset = 1'b0;
        #1;
    endtask

    task automatic timeout_txn(input logic [8:0] a);
        int waited;
        sb_q.push_back(mk_rsp(32'd0, 1'b1, 1'b1));
        issue(1'b0, a, 32'd0);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        waited = 0;
        while (!rsp_valid && waited < 40) begin
            tick();
            waited++;
        end
        check("tmo_wait_cycles", waited, TMO);
        collect_rsp("tmo");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(0, 9'h004, 32'h0,        0, 3'd1, 0, 0, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
        vecs[1]  = mk(1, 9'h010, 32'h12345678, 5, 3'd0, 0, 0, 0, 32'h0,        0, 0, 32'h0);
        vecs[2]  = mk(0, 9'h003, 32'h0,        0, 3'd1, 0, 0, 0, 32'h0,        1, 1, 32'h0);
        vecs[3]  = mk(0, 9'h008, 32'h0,        0, 3'd1, 1, 0, 0, 32'hAAAA5555, 0, 1, 32'h0);
        vecs[4]  = mk(0, 9'h00C, 32'h0,        0, 3'd0, 0, 0, 0, 32'h11112222, 0, 1, 32'h0);
        vecs[5]  = mk(0, 9'h020, 32'h0,        1, 3'd1, 0, 1, 0, 32'h33334444, 0, 1, 32'h0);
        vecs[6]  = mk(1, 9'h1FC, 32'hFFFFFFFF, 2, 3'd0, 0, 1, 0, 32'h0,        0, 0, 32'h0);
        vecs[7]  = mk(0, 9'h100, 32'h0,        0, 3'd1, 0, 0, 1, 32'h55556666, 0, 1, 32'h0);
        vecs[8]  = mk(1, 9'h002, 32'hABCDEF01, 0, 3'd0, 0, 0, 0, 32'h0,        1, 1, 32'h0);
        vecs[9]  = mk(1, 9'h040, 32'h87654321, 0, 3'd1, 0, 0, 0, 32'h0,        0, 1, 32'h0);
        vecs[10] = mk(0, 9'h1FC, 32'h0,        0, 3'd1, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF);

        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        rsp_ready = 0; a_ready = 0;
        d_valid = 0; d_opcode = '0; d_param = '0; d_size = '0; d_source = 0;
        d_sink = 0; d_denied = 0; d_data = '0; d_corrupt = 0;

        do_reset();
        check("post_rst_busy",      busy,      1'b0);
        check("post_rst_req_ready", req_ready, 1'b1);
        check("post_rst_d_ready",   d_ready,   1'b1);
        check("post_rst_proto_err", proto_err, 1'b0);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);
        check("table_proto_err", proto_err, 1'b0);

        // Timeout, then two late beats: first is the stale answer, second is unexpected.
        timeout_txn(9'h014);
        check("tmo_idle_busy", busy, 1'b0);
        d_beat(3'd1, 0, 0, 0, 32'h1);
        check("late_beat1_proto_err", proto_err, 1'b0);
        d_beat(3'd1, 0, 0, 0, 32'h2);
        check("late_beat2_proto_err", proto_err, 1'b1);

        // Reset drops the stale marker, so the late beat becomes a protocol error.
        do_reset();
        check("rst_clears_proto_err", proto_err, 1'b0);
        timeout_txn(9'h018);
        do_reset();
        d_beat(3'd1, 0, 0, 0, 32'h3);
        check("stale_dropped_by_reset", proto_err, 1'b1);

        // Unsolicited beat in IDLE.
        do_reset();
        d_beat(3'd0, 0, 0, 0, 32'h0);
        check("unsolicited_proto_err", proto_err, 1'b1);

        // Reset while waiting in D_WAIT.
        do_reset();
        issue(1'b0, 9'h030, 32'd0);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        check("dwait_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_busy",      busy,      1'b0);
        check("mid_rst_req_ready", req_ready, 1'b1);

        // Response back-pressure with a new request waiting.
        sb_q.push_back(mk_rsp(32'h0BADF00D, 1'b0, 1'b0));
        issue(1'b0, 9'h018, 32'd0);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        d_beat(3'd1, 0, 0, 0, 32'h0BADF00D);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h01C; req_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_rdata",     rsp_rdata, 32'h0BADF00D);
            check("bp_error",     rsp_error, 1'b0);
            tick();
        end
        collect_rsp("bp");
        check("bp_next_req_ready", req_ready, 1'b1);
        sb_q.push_back(mk_rsp(32'd0, 1'b0, 1'b0));
        tick();
        req_valid = 1'b0;
        check("bp_next_a_valid",  a_valid,   1'b1);
        check("bp_next_a_addr",   a_address, 9'h01C);
        check("bp_next_a_data",   a_data,    32'hCAFEF00D);
        check("bp_next_a_opcode", a_opcode,  3'd0);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        d_beat(3'd0, 0, 0, 0, 32'h0);
        collect_rsp("bp_next");
        check("final_proto_err", proto_err, 1'b0);
        check("final_sb_empty",  sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
